ad9643_spi_cfg: RTL

Configuration controller for the AD9643 dual ADC's 3-wire SPI port (sclk/csb/sdio). After reset it reads the chip ID and plays a fixed register table followed by a transfer command. It then serves single-register read/write requests from the host over a valid/ready handshake. It sits between the system control logic and the ADC pins; the sdio tri-state buffer lives in the top level.

---
 rtl/ad9643_spi_pkg.sv | 53 +++++
 rtl/ad9643_spi_shift.sv | 108 ++++++++++
 rtl/ad9643_spi_cfg.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ad9643_spi_pkg.sv
// ad9643_spi_pkg: register constants, frame layout, FSM encodings and the power-up register table.
// Rev 1.0
`default_nettype none

package ad9643_spi_pkg;

  localparam logic [12:0] CHIP_ID     = 13'h001;
  localparam logic [12:0] TRANSFER    = 13'h0FF;
  localparam logic [7:0]  CHIP_ID_VAL = 8'h82;

  typedef struct packed {
    logic        rw;
    logic [1:0]  w;
    logic [12:0] addr;
    logic [7:0]  data;
  } frame_t;

  typedef enum logic [2:0] {
    ENG_IDLE  = 3'd0,
    ENG_SETUP = 3'd1,
    ENG_SHIFT = 3'd2,
    ENG_HOLD  = 3'd3,
    ENG_GAP   = 3'd4
  } eng_state_t;

  typedef enum logic [2:0] {
    SEQ_INIT_ID   = 3'd0,
    SEQ_INIT_TBL  = 3'd1,
    SEQ_INIT_XFER = 3'd2,
    SEQ_IDLE      = 3'd3,
    SEQ_HOST      = 3'd4
  } seq_state_t;

  // Returns {addr, data}; entries past the populated range are harmless zero writes.
  function automatic logic [20:0] init_entry(input logic [4:0] idx);
    logic [20:0] e;
    case (idx)
      5'd0:    e = {13'h008, 8'h00};
      5'd1:    e = {13'h014, 8'h01};
      5'd2:    e = {13'h015, 8'h22};
      5'd3:    e = {13'h016, 8'h00};
      5'd4:    e = {13'h017, 8'h00};
      5'd5:    e = {13'h018, 8'h04};
      5'd6:    e = {13'h00B, 8'h00};
      5'd7:    e = {13'h00D, 8'h00};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ad9643_spi_shift.sv
// ad9643_spi_shift: 24-bit 3-wire SPI bit engine (SETUP, SHIFT, HOLD, GAP).
// Rev 1.0
`default_nettype none

module ad9643_spi_shift
  import ad9643_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  frame_t     frame,
  input  logic       is_read,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       csb,
  output logic       sdio_o,
  output logic       sdio_oe,
  input  logic       sdio_i
);

  localparam int            DW      = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  eng_state_t    state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [23:0]   tx;
  logic          rd;
  logic          half_end;

  assign half_end = (div_cnt == DIV_MAX);
  assign busy     = (state != ENG_IDLE);
  assign done     = (state == ENG_HOLD) && half_end;

  always_comb begin
    state_nxt = state;
    case (state)
      ENG_IDLE:  if (start) state_nxt = ENG_SETUP;
      ENG_SETUP: if (half_end) state_nxt = ENG_SHIFT;
      ENG_SHIFT: if (half_end && sclk && bit_cnt == 5'd0) state_nxt = ENG_HOLD;
      ENG_HOLD:  if (half_end) state_nxt = ENG_GAP;
      ENG_GAP:   if (half_end) state_nxt = ENG_IDLE;
      default:   state_nxt = ENG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ENG_IDLE;
      div_cnt <= '0;
      bit_cnt <= 5'd23;
      tx      <= '0;
      rd      <= 1'b0;
      rdata   <= 8'h00;
      sclk    <= 1'b0;
      csb     <= 1'b1;
      sdio_o  <= 1'b0;
      sdio_oe <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= (state == ENG_IDLE || half_end) ? '0 : div_cnt + 1'b1;
      case (state)
        ENG_IDLE: begin
          if (start) begin
            csb     <= 1'b0;
            sdio_o  <= frame[23];
            tx      <= {frame[22:0], 1'b0};
            sdio_oe <= 1'b1;
            rd      <= is_read;
            bit_cnt <= 5'd23;
          end
        end
        ENG_SHIFT: begin
          if (half_end) begin
            if (!sclk) begin
              sclk <= 1'b1;
              if (rd && bit_cnt <= 5'd7) rdata <= {rdata[6:0], sdio_i};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt != 5'd0) begin
                bit_cnt <= bit_cnt - 5'd1;
                sdio_o  <= tx[23];
                tx      <= {tx[22:0], 1'b0};
                // Turn the line around once the last address bit is out.
                if (rd && bit_cnt == 5'd8) sdio_oe <= 1'b0;
              end
            end
          end
        end
        ENG_HOLD: begin
          if (half_end) begin
            csb     <= 1'b1;
            sdio_oe <= 1'b1;
            sdio_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ad9643_spi_cfg.sv
// ad9643_spi_cfg: AD9643 power-up configuration sequencer plus host register access port.
// Rev 1.0
`default_nettype none

module ad9643_spi_cfg
  import ad9643_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int N_INIT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [12:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        init_done,
  output logic        id_err,
  output logic        sclk,
  output logic        csb,
  output logic        sdio_o,
  output logic        sdio_oe,
  input  logic        sdio_i
);

  seq_state_t state, state_nxt;
  logic [4:0] init_idx;
  logic       host_rw;
  logic       idle_seen;
  logic       start, busy, done, is_read, accept, last_tbl;
  logic [7:0] eng_rdata;
  frame_t     frame;

  assign last_tbl  = (({1'b0, init_idx} + 6'd1) == 6'(N_INIT));
  assign req_ready = (state == SEQ_IDLE) && !busy;
  assign accept    = req_ready && req_valid;
  assign init_done = idle_seen || req_ready;

  // Host frames launch in the acceptance cycle, straight from the request fields.
  always_comb begin
    state_nxt = state;
    frame     = '0;
    is_read   = 1'b0;
    start     = 1'b0;
    case (state)
      SEQ_INIT_ID: begin
        frame.rw   = 1'b1;
        frame.addr = CHIP_ID;
        is_read    = 1'b1;
        start      = !busy;
        if (done) state_nxt = (N_INIT == 0) ? SEQ_INIT_XFER : SEQ_INIT_TBL;
      end
      SEQ_INIT_TBL: begin
        {frame.addr, frame.data} = init_entry(init_idx);
        start = !busy;
        if (done && last_tbl) state_nxt = SEQ_INIT_XFER;
      end
      SEQ_INIT_XFER: begin
        frame.addr = TRANSFER;
        frame.data = 8'h01;
        start      = !busy;
        if (done) state_nxt = SEQ_IDLE;
      end
      SEQ_IDLE: begin
        frame.rw   = req_rw;
        frame.addr = req_addr;
        frame.data = req_rw ? 8'h00 : req_wdata;
        is_read    = req_rw;
        start      = accept;
        if (accept) state_nxt = SEQ_HOST;
      end
      SEQ_HOST: if (done) state_nxt = SEQ_IDLE;
      default:  state_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEQ_INIT_ID;
      init_idx  <= 5'd0;
      host_rw   <= 1'b0;
      idle_seen <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      id_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= 1'b0;
      idle_seen <= idle_seen || req_ready;
      if (accept) host_rw <= req_rw;
      if (done) begin
        case (state)
          SEQ_INIT_ID:  if (eng_rdata != CHIP_ID_VAL) id_err <= 1'b1;
          SEQ_INIT_TBL: init_idx <= init_idx + 5'd1;
          SEQ_HOST: begin
            rsp_valid <= 1'b1;
            rsp_rdata <= host_rw ? eng_rdata : 8'h00;
          end
          default: ;
        endcase
      end
    end
  end

  ad9643_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .frame   (frame),
    .is_read (is_read),
    .busy    (busy),
    .done    (done),
    .rdata   (eng_rdata),
    .sclk    (sclk),
    .csb     (csb),
    .sdio_o  (sdio_o),
    .sdio_oe (sdio_oe),
    .sdio_i  (sdio_i)
  );

endmodule

`default_nettype wire
